// File: rtl/mac_pkg.sv
// mac_pkg: shared types and widths for the MAC sequencer.
package mac_pkg;
    localparam int ACC_W    = 16;
    localparam int OP_W_DEF = 8;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/mac_acc_unit.sv
// mac_acc_unit: multiplier, 16-bit accumulator and sticky overflow flag.
// MAC_SEQ_SATURATE_EN: clamp the accumulator at all-ones instead of wrapping.
module mac_acc_unit import mac_pkg::*; #(
    parameter int OP_W = OP_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [OP_W-1:0]  i_a,
    input  logic [OP_W-1:0]  i_b,
    output logic [ACC_W-1:0] o_acc,
    output logic             o_ovf
);
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [ACC_W-1:0] w_prod;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_next;
    assign w_prod = {{OP_W{1'b0}}, i_a} * {{OP_W{1'b0}}, i_b};
    assign w_sum  = {1'b0, r_acc} + {1'b0, w_prod};
`ifdef MAC_SEQ_SATURATE_EN
    assign w_next = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
`else
    assign w_next = w_sum[ACC_W-1:0];
`endif
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (i_clr) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (i_en) begin
            r_acc <= w_next;
            r_ovf <= r_ovf | w_sum[ACC_W];
        end
    end
    assign o_acc = r_acc;
    assign o_ovf = r_ovf;
endmodule

// File: rtl/mac_sequencer.sv
// mac_sequencer: length-counted multiply-accumulate job sequencer (IDLE/RUN/DONE).
// MAC_SEQ_SATURATE_EN selects a saturating accumulator in mac_acc_unit.
module mac_sequencer import mac_pkg::*; #(
    parameter int LEN_W = 8,
    parameter int OP_W  = OP_W_DEF
) (
    input  logic             seq_clk_i,
    input  logic             seq_nreset_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             clear_i,
    input  logic [OP_W-1:0]  a_i,
    input  logic [OP_W-1:0]  b_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic             busy_o,
    output logic             done_o,
    input  logic             ack_i,
    output logic [ACC_W-1:0] result_o,
    output logic             ovf_o
);
    state_t           r_state;
    logic [LEN_W-1:0] r_cnt;
    logic             w_hs;
    logic             w_clr;
    assign w_hs  = in_valid_i && r_state == RUN;
    // accepting a start zeroes the datapath the same way an abort does
    assign w_clr = clear_i || (r_state == IDLE && start_i);
    always_ff @(posedge seq_clk_i or negedge seq_nreset_i) begin
        if (!seq_nreset_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (clear_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: if (start_i) begin
                    r_cnt   <= len_i;
                    r_state <= (len_i == '0) ? DONE : RUN;
                end
                RUN: if (in_valid_i) begin
                    r_cnt   <= r_cnt - LEN_W'(1);
                    r_state <= (r_cnt == LEN_W'(1)) ? DONE : RUN;
                end
                DONE: if (ack_i) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
    assign in_ready_o = r_state == RUN;
    assign busy_o     = r_state != IDLE;
    assign done_o     = r_state == DONE;
    mac_acc_unit #(.OP_W(OP_W)) u_acc (
        .i_clk   (seq_clk_i),
        .i_rst_n (seq_nreset_i),
        .i_clr   (w_clr),
        .i_en    (w_hs),
        .i_a     (a_i),
        .i_b     (b_i),
        .o_acc   (result_o),
        .o_ovf   (ovf_o)
    );
endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: randomized and directed checks of mac_sequencer against a sum-of-products model.
module tb_mac_sequencer;
    logic        seq_clk_i = 1'b0;
    logic        seq_nreset_i = 1'b0;
    logic        start_i = 1'b0;
    logic [7:0]  len_i = '0;
    logic        clear_i = 1'b0;
    logic [7:0]  a_i = '0;
    logic [7:0]  b_i = '0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic        busy_o;
    logic        done_o;
    logic        ack_i = 1'b0;
    logic [15:0] result_o;
    logic        ovf_o;
    bit          clk_en = 1'b1;
    int          n_err = 0;
    int          n_chk = 0;
    int          qa[$];
    int          qb[$];
    bit          qv[$];

    mac_sequencer dut (
        .seq_clk_i    (seq_clk_i),
        .seq_nreset_i (seq_nreset_i),
        .start_i      (start_i),
        .len_i        (len_i),
        .clear_i      (clear_i),
        .a_i          (a_i),
        .b_i          (b_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .ack_i        (ack_i),
        .result_o     (result_o),
        .ovf_o        (ovf_o)
    );

    always #5 if (clk_en) seq_clk_i = ~seq_clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge seq_clk_i);
        #1;
    endtask

    // the true sum of products mapped onto a 16-bit accumulator
    function automatic int exp_acc(input int sum);
`ifdef MAC_SEQ_SATURATE_EN
        return (sum > 65535) ? 65535 : sum;
`else
        return sum % 65536;
`endif
    endfunction

    task automatic run_job(input int len, input bit ack_with_start);
        int sum = 0;
        int k = 0;
        int cyc = 0;
        bit v;
        start_i = 1'b1;
        len_i = len[7:0];
        step();
        start_i = 1'b0;
        chk("busy_after_start", busy_o, 1);
        chk("ready_after_start", in_ready_o, len > 0);
        chk("acc_cleared", result_o, 0);
        while (k < len && cyc < 400) begin
            v = (qv.size() > 0) ? qv.pop_front() : ($urandom_range(0, 3) != 0);
            in_valid_i = v;
            a_i = qa[k][7:0];
            b_i = qb[k][7:0];
            step();
            cyc++;
            if (v) begin
                sum += qa[k] * qb[k];
                k++;
            end
            chk("acc_run", result_o, exp_acc(sum));
            chk("done_run", done_o, k == len);
            chk("ready_run", in_ready_o, k < len);
        end
        in_valid_i = 1'b0;
        if (k < len) chk("job_timeout", k, len);
        chk("done", done_o, 1);
        chk("ready_in_done", in_ready_o, 0);
        chk("result", result_o, exp_acc(sum));
        chk("ovf", ovf_o, sum > 65535);
        repeat (2) begin
            start_i = $urandom_range(0, 1);
            in_valid_i = 1'b1;
            step();
            chk("done_hold", done_o, 1);
            chk("result_hold", result_o, exp_acc(sum));
            chk("ovf_hold", ovf_o, sum > 65535);
        end
        in_valid_i = 1'b0;
        ack_i = 1'b1;
        start_i = ack_with_start;
        step();
        ack_i = 1'b0;
        start_i = 1'b0;
        chk("done_after_ack", done_o, 0);
        chk("busy_after_ack", busy_o, 0);
        step();
        chk("idle_stays", busy_o, 0);
        chk("result_in_idle", result_o, exp_acc(sum));
        qa.delete();
        qb.delete();
        qv.delete();
    endtask

    initial begin
        step();
        chk("rst_ready", in_ready_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_ovf", ovf_o, 0);
        seq_nreset_i = 1'b1;
        step();
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
        chk("ack_in_idle", busy_o, 0);
        qa = '{2, 4, 1};
        qb = '{3, 5, 1};
        qv = '{1, 1, 1};
        run_job(3, 1'b0);
        run_job(0, 1'b0);
        qa = '{255, 255};
        qb = '{255, 255};
        qv = '{1, 1};
        run_job(2, 1'b1);
        qa = '{1, 1, 1, 1};
        qb = '{1, 1, 1, 1};
        qv = '{1, 0, 0, 1, 1, 0, 1};
        run_job(4, 1'b0);
        // abort part-way, with a handshake offered in the same cycle
        start_i = 1'b1;
        len_i = 8'd5;
        step();
        start_i = 1'b0;
        in_valid_i = 1'b1;
        a_i = 8'd10;
        b_i = 8'd20;
        step();
        step();
        chk("partial_acc", result_o, 400);
        clear_i = 1'b1;
        start_i = 1'b1;
        step();
        clear_i = 1'b0;
        start_i = 1'b0;
        in_valid_i = 1'b0;
        chk("clear_busy", busy_o, 0);
        chk("clear_result", result_o, 0);
        chk("clear_ovf", ovf_o, 0);
        step();
        chk("clear_beats_start", busy_o, 0);
        qa = '{3};
        qb = '{3};
        qv = '{1};
        run_job(1, 1'b0);
        // asynchronous reset with the clock frozen
        start_i = 1'b1;
        len_i = 8'd5;
        step();
        start_i = 1'b0;
        in_valid_i = 1'b1;
        a_i = 8'd7;
        b_i = 8'd9;
        step();
        step();
        in_valid_i = 1'b0;
        chk("pre_reset_acc", result_o, 126);
        clk_en = 1'b0;
        #20;
        seq_nreset_i = 1'b0;
        #1;
        chk("arst_ready", in_ready_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_result", result_o, 0);
        chk("arst_ovf", ovf_o, 0);
        #5;
        seq_nreset_i = 1'b1;
        clk_en = 1'b1;
        step();
        chk("post_reset_idle", busy_o, 0);
        // long ack: done drops once and stays low
        start_i = 1'b1;
        len_i = 8'd0;
        step();
        start_i = 1'b0;
        chk("zero_len_done", done_o, 1);
        ack_i = 1'b1;
        repeat (5) begin
            step();
            chk("long_ack_done", done_o, 0);
            chk("long_ack_busy", busy_o, 0);
        end
        ack_i = 1'b0;
        for (int j = 0; j < 25; j++) begin
            int len;
            len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                qa.push_back(($urandom_range(0, 2) == 0) ? 255 : $urandom_range(0, 255));
                qb.push_back(($urandom_range(0, 2) == 0) ? 255 : $urandom_range(0, 255));
            end
            run_job(len, $urandom_range(0, 1));
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
